// File: rtl/ft_pkg.sv
// Shared types and default constants for the FT lockstep recovery sequencer.
package ft_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HALT,
    RESET,
    REPLAY,
    SPC,
    RESUME,
    FATAL
  } ft_rec_state_e;

  localparam int DEF_HALT_TIMEOUT = 64;
  localparam int DEF_MAX_RETRIES  = 3;
  localparam int DEF_CLEAN_WINDOW = 1024;

endpackage

// File: rtl/ft_recovery_seq.sv
// Lockstep error-recovery sequencer: on a comparator mismatch it freezes the shadow state,
// halts/resets both cores, replays the shadow GPRs, restores the PC and resumes.
module ft_recovery_seq
  import ft_pkg::*;
#(
  parameter int ADDR_WIDTH   = 5,
  parameter int HALT_TIMEOUT = DEF_HALT_TIMEOUT,
  parameter int MAX_RETRIES  = DEF_MAX_RETRIES,
  parameter int CLEAN_WINDOW = DEF_CLEAN_WINDOW
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  error_i,
  input  logic                  halted_i,
  output logic                  we_sgpr_o,
  output logic                  we_spc_o,
  output logic                  halt_o,
  output logic                  reset_o,
  output logic                  replay_we_o,
  output logic [ADDR_WIDTH-1:0] replay_addr_o,
  output logic                  spc_restore_o,
  output logic                  resume_o,
  output logic                  busy_o,
  output logic                  fatal_o,
  output logic [1:0]            retry_cnt_o
);

  localparam int TW = $clog2(HALT_TIMEOUT + 1);
  localparam int CW = $clog2(CLEAN_WINDOW + 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {ADDR_WIDTH{1'b1}};
  localparam logic [1:0]            MAX_R     = 2'(MAX_RETRIES);
  localparam logic [TW-1:0]         TMO_LAST  = TW'(HALT_TIMEOUT - 1);
  localparam logic [CW-1:0]         CLEAN_LAST = CW'(CLEAN_WINDOW - 1);

  ft_rec_state_e   state, state_nx;
  logic [TW-1:0]   timer;
  logic [CW-1:0]   clean_cnt;

  // Write permission is combinational so the mismatching write never lands.
  assign we_sgpr_o = (state == IDLE) & ~error_i;
  assign we_spc_o  = (state == IDLE) & ~error_i;

  always_comb begin
    state_nx      = state;
    halt_o        = 1'b0;
    reset_o       = 1'b0;
    replay_we_o   = 1'b0;
    spc_restore_o = 1'b0;
    resume_o      = 1'b0;
    fatal_o       = 1'b0;
    busy_o        = (state != IDLE);
    case (state)
      IDLE: begin
        if (error_i) state_nx = (retry_cnt_o == MAX_R) ? FATAL : HALT;
      end
      HALT: begin
        halt_o = 1'b1;
        if (halted_i)               state_nx = RESET;
        else if (timer == TMO_LAST) state_nx = FATAL;
      end
      RESET: begin
        halt_o   = 1'b1;
        reset_o  = 1'b1;
        state_nx = REPLAY;
      end
      REPLAY: begin
        halt_o      = 1'b1;
        replay_we_o = 1'b1;
        if (replay_addr_o == LAST_ADDR) state_nx = SPC;
      end
      SPC: begin
        halt_o        = 1'b1;
        spc_restore_o = 1'b1;
        state_nx      = RESUME;
      end
      RESUME: begin
        resume_o = 1'b1;
        if (!halted_i)              state_nx = IDLE;
        else if (timer == TMO_LAST) state_nx = FATAL;
      end
      FATAL: begin
        halt_o  = 1'b1;
        fatal_o = 1'b1;
      end
      default: state_nx = FATAL;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state         <= IDLE;
      timer         <= '0;
      clean_cnt     <= '0;
      retry_cnt_o   <= '0;
      replay_addr_o <= '0;
    end else begin
      state <= state_nx;
      // Timer only matters while waiting on the cores' halted handshake.
      if (state_nx != state)                     timer <= '0;
      else if (state == HALT || state == RESUME) timer <= timer + TW'(1);

      if (state == IDLE) begin
        if (error_i) begin
          clean_cnt <= '0;
          if (retry_cnt_o < MAX_R) retry_cnt_o <= retry_cnt_o + 2'd1;
        end else if (clean_cnt == CLEAN_LAST) begin
          clean_cnt   <= '0;
          retry_cnt_o <= '0;
        end else begin
          clean_cnt <= clean_cnt + CW'(1);
        end
      end

      if (state == RESET)
        replay_addr_o <= ADDR_WIDTH'(1);
      else if (state == REPLAY && replay_addr_o != LAST_ADDR)
        replay_addr_o <= replay_addr_o + ADDR_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_ft_recovery_seq.sv
// Scoreboard bench: the driver predicts each cycle's outputs from a recovery-timeline model,
// a negedge monitor pops and compares against the DUT.
module tb_ft_recovery_seq;

  localparam int NREG = 31;          // replayed registers 1..31
  localparam int TMO  = 64;
  localparam int MAXR = 3;
  localparam int WIN  = 1024;

  localparam int P_IDLE = 0, P_WAIT = 1, P_SEQ = 2, P_RES = 3, P_FATAL = 4;

  logic clk = 1'b0;
  logic rst_i = 1'b1, error_i = 1'b0, halted_i = 1'b0;
  logic we_sgpr_o, we_spc_o, halt_o, reset_o, replay_we_o, spc_restore_o;
  logic resume_o, busy_o, fatal_o;
  logic [4:0] replay_addr_o;
  logic [1:0] retry_cnt_o;

  always #5 clk = ~clk;

  ft_recovery_seq dut (
    .clk_i(clk), .rst_i(rst_i), .error_i(error_i), .halted_i(halted_i),
    .we_sgpr_o(we_sgpr_o), .we_spc_o(we_spc_o), .halt_o(halt_o), .reset_o(reset_o),
    .replay_we_o(replay_we_o), .replay_addr_o(replay_addr_o), .spc_restore_o(spc_restore_o),
    .resume_o(resume_o), .busy_o(busy_o), .fatal_o(fatal_o), .retry_cnt_o(retry_cnt_o)
  );

  typedef struct {
    int we, halt, rstp, rwe, addr, spc, res, busy, fatal, retry;
  } exp_t;

  exp_t sbq[$];
  int ncmp = 0, nerr = 0;

  // Model: phase plus position within the recovery timeline.
  // k counts cycles since halted_i was seen: 1 = core reset, 2..32 = replay, 33 = PC restore.
  int ph = P_IDLE, k = 0, wt = 0, retry = 0, clean = 0, m_addr = 0;
  bit mvalid = 0;
  int hdelay = 3, rdelay = 3;
  bit err_busy = 0, glitch = 0;

  task automatic chk(input string n, input int a, input int x);
    ncmp++;
    if (a != x) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d at %0t", n, a, x, $time);
    end
  endtask

  always @(negedge clk) begin
    if (sbq.size() > 0) begin
      exp_t x;
      x = sbq.pop_front();
      chk("we_sgpr", int'(we_sgpr_o), x.we);
      chk("we_spc", int'(we_spc_o), x.we);
      chk("halt", int'(halt_o), x.halt);
      chk("reset", int'(reset_o), x.rstp);
      chk("replay_we", int'(replay_we_o), x.rwe);
      chk("replay_addr", int'(replay_addr_o), x.addr);
      chk("spc_restore", int'(spc_restore_o), x.spc);
      chk("resume", int'(resume_o), x.res);
      chk("busy", int'(busy_o), x.busy);
      chk("fatal", int'(fatal_o), x.fatal);
      chk("retry_cnt", int'(retry_cnt_o), x.retry);
    end
  end

  // Simple dual-core behaviour driven from the model's view of the recovery.
  function automatic bit core_h();
    case (ph)
      P_WAIT:  return (hdelay >= 0) && (wt >= hdelay);
      P_SEQ:   return glitch ? ($urandom_range(0, 3) != 0) : 1'b1;
      P_RES:   return wt < rdelay;
      P_FATAL: return 1'($urandom_range(0, 1));
      default: return 1'b0;
    endcase
  endfunction

  function automatic exp_t predict(input bit e);
    exp_t x;
    x.we    = (ph == P_IDLE && !e) ? 1 : 0;
    x.halt  = (ph == P_WAIT || ph == P_SEQ || ph == P_FATAL) ? 1 : 0;
    x.rstp  = (ph == P_SEQ && k == 1) ? 1 : 0;
    x.rwe   = (ph == P_SEQ && k >= 2 && k <= NREG + 1) ? 1 : 0;
    x.addr  = x.rwe ? k - 1 : m_addr;
    x.spc   = (ph == P_SEQ && k == NREG + 2) ? 1 : 0;
    x.res   = (ph == P_RES) ? 1 : 0;
    x.busy  = (ph != P_IDLE) ? 1 : 0;
    x.fatal = (ph == P_FATAL) ? 1 : 0;
    x.retry = retry;
    return x;
  endfunction

  task automatic model_upd(input bit r, input bit e, input bit h);
    if (r) begin
      ph = P_IDLE; k = 0; wt = 0; retry = 0; clean = 0; m_addr = 0; mvalid = 1;
      return;
    end
    case (ph)
      P_IDLE:
        if (e) begin
          clean = 0;
          if (retry == MAXR) ph = P_FATAL;
          else begin ph = P_WAIT; wt = 0; retry++; end
        end else begin
          clean++;
          if (clean == WIN) begin clean = 0; retry = 0; end
        end
      P_WAIT:
        if (h) begin ph = P_SEQ; k = 1; end
        else begin wt++; if (wt == TMO) ph = P_FATAL; end
      P_SEQ: begin
        if (k >= 2 && k <= NREG + 1) m_addr = k - 1;
        if (k == NREG + 2) begin ph = P_RES; wt = 0; end
        else k++;
      end
      P_RES:
        if (!h) ph = P_IDLE;
        else begin wt++; if (wt == TMO) ph = P_FATAL; end
      default: ;
    endcase
  endtask

  task automatic step(input bit r, input bit e_idle);
    bit e, h;
    @(posedge clk); #1;
    e = (ph == P_IDLE) ? e_idle : err_busy;
    h = core_h();
    rst_i = r; error_i = e; halted_i = h;
    if (mvalid) sbq.push_back(predict(e));
    model_upd(r, e, h);
  endtask

  task automatic idle_n(input int n);
    for (int i = 0; i < n; i++) step(0, 0);
  endtask

  task automatic wait_idle(input int bound);
    for (int i = 0; i < bound && ph != P_IDLE; i++) step(0, 0);
    if (ph != P_IDLE) begin
      ncmp++; nerr++;
      $display("FAIL wait_idle: recovery did not complete within %0d cycles", bound);
    end
  endtask

  task automatic recover();
    step(0, 1);
    wait_idle(300);
  endtask

  initial begin
    step(1, 0); step(1, 0);
    // 1: long quiet run, retry stays clear
    idle_n(2000);
    // 2: reference recovery timeline
    step(1, 0);
    idle_n(9);
    hdelay = 3; rdelay = 3;
    recover();
    idle_n(5);
    // 3: cores never halt -> timeout to FATAL, later errors ignored
    step(1, 0);
    hdelay = -1;
    step(0, 1);
    idle_n(70);
    err_busy = 1; idle_n(20); err_busy = 0;
    // 4a: fourth error inside the window is fatal
    step(1, 0);
    hdelay = 2; rdelay = 1;
    for (int i = 0; i < 3; i++) begin recover(); idle_n(40); end
    step(0, 1);
    idle_n(10);
    // 4b: clean gap before the fourth error clears the history
    step(1, 0);
    for (int i = 0; i < 3; i++) begin recover(); idle_n(40); end
    idle_n(1100);
    recover();
    idle_n(5);
    // 5: error hammered throughout recovery
    step(1, 0);
    idle_n(9);
    hdelay = 3; rdelay = 3; err_busy = 1;
    recover();
    err_busy = 0;
    idle_n(5);
    // 6: reset mid-replay
    step(1, 0);
    hdelay = 2;
    step(0, 1);
    for (int i = 0; i < 100 && !(ph == P_SEQ && k == 13); i++) step(0, 0);
    step(1, 0);
    idle_n(10);
    // random traffic
    glitch = 1;
    for (int i = 0; i < 4000; i++) begin
      bit r, e;
      r = (ph == P_FATAL) ? ($urandom_range(0, 19) == 0) : ($urandom_range(0, 999) == 0);
      e = ($urandom_range(0, 59) == 0);
      err_busy = ($urandom_range(0, 3) == 0);
      if (ph == P_IDLE && e) begin
        hdelay = ($urandom_range(0, 19) == 0) ? -1 : int'($urandom_range(0, 8));
        rdelay = ($urandom_range(0, 19) == 0) ? 100 : int'($urandom_range(0, 5));
      end
      step(r, e);
    end
    @(negedge clk); #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
